mips16_multi_cycle_core: RTL



---
 rtl/mips16_multi_cycle_core_if.sv | 36 +++
 rtl/mips16_multi_cycle_core.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/mips16_multi_cycle_core_if.sv
// rtl/mips16_multi_cycle_core_if.sv - host-side control/program/status bus of the multi-cycle MIPS16 core
// Optional cycle_count signal is present only when MIPS16_CYCLE_COUNT_EN is defined.

interface mips16_multi_cycle_core_if #(
  parameter int DATA_W  = 16,
  parameter int IMEM_AW = 4
);
  logic               start;
  logic               prog_we;
  logic [IMEM_AW-1:0] prog_addr;
  logic [15:0]        prog_data;
  logic               busy;
  logic               halted;
  logic               retire;
  logic [IMEM_AW-1:0] pc_out;
  logic [DATA_W-1:0]  alu_out;
`ifdef MIPS16_CYCLE_COUNT_EN
  logic [31:0]        cycle_count;
`endif

  modport master (
    output start, prog_we, prog_addr, prog_data,
`ifdef MIPS16_CYCLE_COUNT_EN
    input  cycle_count,
`endif
    input  busy, halted, retire, pc_out, alu_out
  );

  modport slave (
    input  start, prog_we, prog_addr, prog_data,
`ifdef MIPS16_CYCLE_COUNT_EN
    output cycle_count,
`endif
    output busy, halted, retire, pc_out, alu_out
  );
endinterface

// File: rtl/mips16_multi_cycle_core.sv
// rtl/mips16_multi_cycle_core.sv - multi-cycle MIPS16 core with shared ALU and host-loadable program RAM
// Optional feature macro: MIPS16_CYCLE_COUNT_EN (adds a saturating busy-cycle counter).

module mips16_multi_cycle_core #(
  parameter int DATA_W  = 16,
  parameter int IMEM_AW = 4,
  parameter int DMEM_AW = 6
) (
  input  logic                      clk,
  input  logic                      rst,
  mips16_multi_cycle_core_if.slave  bus
);

  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_ADDI = 4'h2;
  localparam logic [3:0] OP_LW   = 4'h3;
  localparam logic [3:0] OP_SW   = 4'h4;
  localparam logic [3:0] OP_J    = 4'h5;
  localparam logic [3:0] OP_XOR  = 4'h6;
  localparam logic [3:0] OP_OR   = 4'h7;
  localparam logic [3:0] OP_BEQ  = 4'h8;
  localparam logic [3:0] OP_AND  = 4'h9;
  localparam logic [3:0] OP_HALT = 4'hF;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
  } state_t;

  state_t             r_state, w_state_nxt;
  logic [IMEM_AW-1:0] r_pc;
  logic [15:0]        r_ir;
  logic [DATA_W-1:0]  r_alu;
  logic [DATA_W-1:0]  r_mdr;
  logic [DATA_W-1:0]  r_regs [16];
  logic [15:0]        r_imem [2**IMEM_AW];
  logic [DATA_W-1:0]  r_dmem [2**DMEM_AW];

  logic [3:0]         w_op, w_a, w_b, w_c;
  logic [DATA_W-1:0]  w_ra, w_rb, w_rc, w_imm, w_alu_res, w_wb_data;
  logic [IMEM_AW-1:0] w_pc_inc, w_pc_br, w_pc_nxt;
  logic [DMEM_AW-1:0] w_daddr;
  logic               w_busy, w_halted, w_retire;
  logic               w_pc_we, w_ir_we, w_alu_we, w_mdr_we, w_dmem_we, w_rf_we;
  logic               w_prog_we;

  assign w_op      = r_ir[15:12];
  assign w_a       = r_ir[11:8];
  assign w_b       = r_ir[7:4];
  assign w_c       = r_ir[3:0];
  assign w_ra      = r_regs[w_a];
  assign w_rb      = r_regs[w_b];
  assign w_rc      = r_regs[w_c];
  assign w_imm     = {{(DATA_W-4){w_c[3]}}, w_c};
  assign w_pc_inc  = r_pc + IMEM_AW'(1);
  assign w_pc_br   = w_pc_inc + IMEM_AW'($signed(w_imm));
  assign w_daddr   = r_alu[DMEM_AW-1:0];
  assign w_wb_data = (w_op == OP_LW) ? r_mdr : r_alu;
  // The program port is only live while the core is not executing.
  assign w_prog_we = bus.prog_we && ((r_state == S_IDLE) || (r_state == S_HALT));

  // Shared ALU: one adder/logic unit serves arithmetic, logic and address generation.
  always_comb begin
    w_alu_res = '0;
    case (w_op)
      OP_ADD:               w_alu_res = w_rb + w_rc;
      OP_SUB:               w_alu_res = w_rb - w_rc;
      OP_ADDI, OP_LW, OP_SW: w_alu_res = w_rb + w_imm;
      OP_XOR:               w_alu_res = w_rb ^ w_rc;
      OP_OR:                w_alu_res = w_rb | w_rc;
      OP_AND:               w_alu_res = w_rb & w_rc;
      default:              w_alu_res = '0;
    endcase
  end

  // Sequencer state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state logic and per-state datapath strobes.
  always_comb begin
    w_state_nxt = r_state;
    w_busy      = 1'b0;
    w_halted    = 1'b0;
    w_retire    = 1'b0;
    w_pc_we     = 1'b0;
    w_pc_nxt    = r_pc;
    w_ir_we     = 1'b0;
    w_alu_we    = 1'b0;
    w_mdr_we    = 1'b0;
    w_dmem_we   = 1'b0;
    w_rf_we     = 1'b0;
    case (r_state)
      S_IDLE, S_HALT: begin
        w_halted = (r_state == S_HALT);
        if (bus.start) begin
          w_state_nxt = S_FETCH;
          w_pc_we     = 1'b1;
          w_pc_nxt    = '0;
        end
      end
      S_FETCH: begin
        w_busy      = 1'b1;
        w_ir_we     = 1'b1;
        w_state_nxt = S_DECODE;
      end
      S_DECODE: begin
        w_busy = 1'b1;
        if (w_op == OP_HALT) begin
          w_retire    = 1'b1;
          w_state_nxt = S_HALT;
        end else begin
          w_state_nxt = S_EXEC;
        end
      end
      S_EXEC: begin
        w_busy = 1'b1;
        case (w_op)
          OP_ADD, OP_SUB, OP_ADDI, OP_XOR, OP_OR, OP_AND: begin
            w_alu_we    = 1'b1;
            w_state_nxt = S_WB;
          end
          OP_LW, OP_SW: begin
            w_alu_we    = 1'b1;
            w_state_nxt = S_MEM;
          end
          OP_J: begin
            w_retire    = 1'b1;
            w_pc_we     = 1'b1;
            w_pc_nxt    = r_ir[IMEM_AW-1:0];
            w_state_nxt = S_FETCH;
          end
          OP_BEQ: begin
            w_retire    = 1'b1;
            w_pc_we     = 1'b1;
            w_pc_nxt    = (w_ra == w_rb) ? w_pc_br : w_pc_inc;
            w_state_nxt = S_FETCH;
          end
          default: begin
            w_retire    = 1'b1;
            w_pc_we     = 1'b1;
            w_pc_nxt    = w_pc_inc;
            w_state_nxt = S_FETCH;
          end
        endcase
      end
      S_MEM: begin
        w_busy = 1'b1;
        if (w_op == OP_LW) begin
          w_mdr_we    = 1'b1;
          w_state_nxt = S_WB;
        end else begin
          w_dmem_we   = 1'b1;
          w_retire    = 1'b1;
          w_pc_we     = 1'b1;
          w_pc_nxt    = w_pc_inc;
          w_state_nxt = S_FETCH;
        end
      end
      S_WB: begin
        w_busy      = 1'b1;
        w_retire    = 1'b1;
        w_rf_we     = 1'b1;
        w_pc_we     = 1'b1;
        w_pc_nxt    = w_pc_inc;
        w_state_nxt = S_FETCH;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Program counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)          r_pc <= '0;
    else if (w_pc_we) r_pc <= w_pc_nxt;
  end

  // Instruction register, loaded from program RAM in FETCH.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)          r_ir <= '0;
    else if (w_ir_we) r_ir <= r_imem[r_pc];
  end

  // ALU result register; only ALU/LW/SW update it in EXEC.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)           r_alu <= '0;
    else if (w_alu_we) r_alu <= w_alu_res;
  end

  // Memory data register for loads.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)           r_mdr <= '0;
    else if (w_mdr_we) r_mdr <= r_dmem[w_daddr];
  end

  // Register file; reset preloads reg[i]=i so programs have known operands.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) r_regs[i] <= DATA_W'(i);
    end else if (w_rf_we) begin
      r_regs[w_a] <= w_wb_data;
    end
  end

  // Program RAM write port (not reset).
  always_ff @(posedge clk) begin
    if (w_prog_we) r_imem[bus.prog_addr] <= bus.prog_data;
  end

  // Data RAM write port for SW (not reset).
  always_ff @(posedge clk) begin
    if (w_dmem_we) r_dmem[w_daddr] <= w_ra;
  end

`ifdef MIPS16_CYCLE_COUNT_EN
  logic [31:0] r_cycle_count;
  logic        w_start_ok;
  assign w_start_ok = bus.start && ((r_state == S_IDLE) || (r_state == S_HALT));

  // Saturating count of busy cycles, restarted by every accepted start.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                 r_cycle_count <= '0;
    else if (w_start_ok)                     r_cycle_count <= '0;
    else if (w_busy && (r_cycle_count != '1)) r_cycle_count <= r_cycle_count + 32'd1;
  end

  assign bus.cycle_count = r_cycle_count;
`endif

  assign bus.busy    = w_busy;
  assign bus.halted  = w_halted;
  assign bus.retire  = w_retire;
  assign bus.pc_out  = r_pc;
  assign bus.alu_out = r_alu;

endmodule
